// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Multi-cycle control FSM for the 16-bit datapath. Owns the program
//   counter, instruction register and (optionally) the Z/N/C condition
//   flags; fetches from block RAM, decodes, and drives every datapath
//   mux select and enable from the registered state and IR only.
//
//   Optional feature macro: DATAPATH_SEQ_BRANCH_EN
//     defined   -> Bcond (opcode 1100) implemented, flags register kept
//     undefined -> opcode 1100 is a NOP, no flags, PC only increments
//
//   Ports
//     clock, reset (async, active-low), run (level, permits fetch)
//     ramReadData                      fetched word / load data
//     aluZero/aluNegative/aluCarry     ALU flags, valid in EXECUTE
//     instruction, programCounter      IR and PC to the datapath
//     blockRamReadEnable/WriteEnable, registerFileWriteEnable
//     integerTypeSelectionLine         00 raw, 01 sign-ext, 10 zero-ext
//     reg2OrImmediateSelectionLine     0 reg2, 1 immediate
//     pcOrRegisterSelectionLine        0 PC,   1 reg1 on ALU input A
//     addressFromRegOrDecoderSelectionLine  0 reg2 as RAM write address
//     writeBackToRegRamOrALUSelectionLine   0 RAM data, 1 ALU result
//     pcOrAluOutputRamReadSelectionLine     1 PC, 0 ALU result
//     registerWriteAddress             IR[11:8]
//     halted                           1 while in HALT
module datapath_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ramReadData,
  input  logic        aluZero,
  input  logic        aluNegative,
  input  logic        aluCarry,
  output logic [15:0] instruction,
  output logic [15:0] programCounter,
  output logic        blockRamReadEnable,
  output logic        blockRamWriteEnable,
  output logic        registerFileWriteEnable,
  output logic [1:0]  integerTypeSelectionLine,
  output logic        reg2OrImmediateSelectionLine,
  output logic        pcOrRegisterSelectionLine,
  output logic        addressFromRegOrDecoderSelectionLine,
  output logic        writeBackToRegRamOrALUSelectionLine,
  output logic        pcOrAluOutputRamReadSelectionLine,
  output logic [3:0]  registerWriteAddress,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, EXECUTE, MEM, WRITEBACK, HALT
  } stateType;

  stateType    state, nextState;
  logic [15:0] pcReg;
  logic [15:0] irReg;

  logic [3:0] opcode;
  logic [3:0] ext;
  logic       isAluR, isAluI, isAlu, isLoad, isStor, isHalt, isCompare;
  logic       signExtImm;

  assign opcode = irReg[15:12];
  assign ext    = irReg[7:4];

  assign isAluR    = (opcode == 4'h0);
  assign isAluI    = (opcode >= 4'h1) && (opcode <= 4'hB) && (opcode != 4'h4);
  assign isAlu     = isAluR || isAluI;
  assign isLoad    = (opcode == 4'h4) && (ext == 4'h0);
  assign isStor    = (opcode == 4'h4) && (ext == 4'h4);
  assign isHalt    = (opcode == 4'h4) && (ext == 4'h1);
  // CMP and CMPI only set flags; they never write the register file
  assign isCompare = (isAluR && (ext == 4'hB)) || (opcode == 4'hB);
  assign signExtImm = (opcode == 4'h5) || (opcode == 4'h9) || (opcode == 4'hB);

`ifdef DATAPATH_SEQ_BRANCH_EN
  logic        zeroFlag, negFlag, carryFlag;
  logic        isBranch, branchTaken;
  logic [15:0] branchTarget;

  assign isBranch = (opcode == 4'hC);
  // PC already points past the branch when this is applied
  assign branchTarget = pcReg + {{8{irReg[7]}}, irReg[7:0]};

  always_comb begin
    branchTaken = 1'b0;
    case (irReg[11:8])
      4'h0:    branchTaken = zeroFlag;
      4'h1:    branchTaken = !zeroFlag;
      4'h2:    branchTaken = carryFlag;
      4'h3:    branchTaken = !carryFlag;
      4'hC:    branchTaken = negFlag;
      4'hD:    branchTaken = !negFlag;
      4'hE:    branchTaken = 1'b1;
      default: branchTaken = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zeroFlag  <= 1'b0;
      negFlag   <= 1'b0;
      carryFlag <= 1'b0;
    end else if ((state == EXECUTE) && isAlu) begin
      zeroFlag  <= aluZero;
      negFlag   <= aluNegative;
      carryFlag <= aluCarry;
    end
  end
`else
  logic unusedFlagInputs;
  assign unusedFlagInputs = ^{aluZero, aluNegative, aluCarry};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pcReg <= RESET_PC;
      irReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) begin
        irReg <= ramReadData;
        pcReg <= pcReg + 16'd1;
      end
`ifdef DATAPATH_SEQ_BRANCH_EN
      else if ((state == EXECUTE) && isBranch && branchTaken) begin
        pcReg <= branchTarget;
      end
`endif
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:       if (run) nextState = FETCH;
      FETCH:      nextState = FETCH_WAIT;
      FETCH_WAIT: nextState = DECODE;
      DECODE:     nextState = EXECUTE;
      EXECUTE: begin
        if (isLoad)      nextState = MEM;
        else if (isHalt) nextState = HALT;
        else             nextState = run ? FETCH : IDLE;
      end
      MEM:        nextState = WRITEBACK;
      WRITEBACK:  nextState = run ? FETCH : IDLE;
      HALT:       nextState = HALT;
      default:    nextState = IDLE;
    endcase
  end

  always_comb begin
    blockRamReadEnable                   = 1'b0;
    blockRamWriteEnable                  = 1'b0;
    registerFileWriteEnable              = 1'b0;
    integerTypeSelectionLine             = 2'b00;
    reg2OrImmediateSelectionLine         = 1'b0;
    pcOrRegisterSelectionLine            = 1'b0;
    addressFromRegOrDecoderSelectionLine = 1'b0;
    writeBackToRegRamOrALUSelectionLine  = 1'b0;
    pcOrAluOutputRamReadSelectionLine    = 1'b0;
    case (state)
      FETCH: begin
        blockRamReadEnable                = 1'b1;
        pcOrAluOutputRamReadSelectionLine = 1'b1;
      end
      EXECUTE: begin
        if (isAlu) begin
          pcOrRegisterSelectionLine           = 1'b1;
          writeBackToRegRamOrALUSelectionLine = 1'b1;
          registerFileWriteEnable             = !isCompare;
          if (isAluI) begin
            reg2OrImmediateSelectionLine = 1'b1;
            integerTypeSelectionLine     = signExtImm ? 2'b01 : 2'b10;
          end
        end else if (isLoad) begin
          blockRamReadEnable = 1'b1;
        end else if (isStor) begin
          blockRamWriteEnable = 1'b1;
        end
      end
      WRITEBACK: begin
        registerFileWriteEnable = 1'b1;
      end
      default: ;
    endcase
  end

  assign instruction          = irReg;
  assign programCounter       = pcReg;
  assign registerWriteAddress = irReg[11:8];
  assign halted               = (state == HALT);

endmodule

// File: tb/tb_datapath_sequencer.sv
module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] ramReadData = '0;
  logic        aluZero = 1'b0, aluNegative = 1'b0, aluCarry = 1'b0;

  logic [15:0] instruction, programCounter;
  logic        blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable;
  logic [1:0]  integerTypeSelectionLine;
  logic        reg2OrImmediateSelectionLine, pcOrRegisterSelectionLine;
  logic        addressFromRegOrDecoderSelectionLine;
  logic        writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine;
  logic [3:0]  registerWriteAddress;
  logic        halted;

  // second instance only to observe PC wrap from 16'hFFFF
  logic [15:0] wInstr, wPc;
  logic        wRe, wWe, wRw, wRi, wPr, wAs, wWb, wPs, wHalt;
  logic [1:0]  wIt;
  logic [3:0]  wRa;

  datapath_sequencer #(.RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .run(run), .ramReadData(ramReadData),
    .aluZero(aluZero), .aluNegative(aluNegative), .aluCarry(aluCarry),
    .instruction(instruction), .programCounter(programCounter),
    .blockRamReadEnable(blockRamReadEnable), .blockRamWriteEnable(blockRamWriteEnable),
    .registerFileWriteEnable(registerFileWriteEnable),
    .integerTypeSelectionLine(integerTypeSelectionLine),
    .reg2OrImmediateSelectionLine(reg2OrImmediateSelectionLine),
    .pcOrRegisterSelectionLine(pcOrRegisterSelectionLine),
    .addressFromRegOrDecoderSelectionLine(addressFromRegOrDecoderSelectionLine),
    .writeBackToRegRamOrALUSelectionLine(writeBackToRegRamOrALUSelectionLine),
    .pcOrAluOutputRamReadSelectionLine(pcOrAluOutputRamReadSelectionLine),
    .registerWriteAddress(registerWriteAddress), .halted(halted)
  );

  datapath_sequencer #(.RESET_PC(16'hFFFF)) dutWrap (
    .clock(clock), .reset(reset), .run(run), .ramReadData(ramReadData),
    .aluZero(aluZero), .aluNegative(aluNegative), .aluCarry(aluCarry),
    .instruction(wInstr), .programCounter(wPc),
    .blockRamReadEnable(wRe), .blockRamWriteEnable(wWe),
    .registerFileWriteEnable(wRw), .integerTypeSelectionLine(wIt),
    .reg2OrImmediateSelectionLine(wRi), .pcOrRegisterSelectionLine(wPr),
    .addressFromRegOrDecoderSelectionLine(wAs),
    .writeBackToRegRamOrALUSelectionLine(wWb),
    .pcOrAluOutputRamReadSelectionLine(wPs),
    .registerWriteAddress(wRa), .halted(wHalt)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:65535];

  // registered block RAM; non-PC reads return arbitrary load data
  always @(posedge clock)
    if (blockRamReadEnable)
      ramReadData <= pcOrAluOutputRamReadSelectionLine ? mem[programCounter] : 16'($urandom);

  int checkCount = 0;
  int passCount  = 0;

  // ---------------- instruction-level reference model ----------------
  // cls: 0 NOP, 1 R-type ALU, 2 immediate ALU, 3 LOAD, 4 STOR, 5 HALT, 6 Bcond
  function automatic int cls(input logic [15:0] w);
    logic [3:0] op, ex;
    op = w[15:12];
    ex = w[7:4];
    if (op == 4'h0) return 1;
    if (op == 4'h4) begin
      if (ex == 4'h0) return 3;
      if (ex == 4'h4) return 4;
      if (ex == 4'h1) return 5;
      return 0;
    end
    if (op <= 4'hB) return 2;
`ifdef DATAPATH_SEQ_BRANCH_EN
    if (op == 4'hC) return 6;
`endif
    return 0;
  endfunction

  logic [15:0] mPc, mIr;
  logic        mZ, mN, mC;
  logic        mBusy, mHalted;
  int          mCyc;  // 1-based cycle within the current instruction

  task automatic modelReset();
    mPc = 16'h0000; mIr = '0;
    mZ = 0; mN = 0; mC = 0;
    mBusy = 0; mHalted = 0; mCyc = 0;
  endtask

  function automatic logic condTrue(input logic [3:0] c);
    case (c)
      4'h0: return mZ;
      4'h1: return !mZ;
      4'h2: return mC;
      4'h3: return !mC;
      4'hC: return mN;
      4'hD: return !mN;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // advance the model across one rising edge
  task automatic modelStep();
    int k, len;
    if (mHalted) return;
    if (!mBusy) begin
      if (run) begin mBusy = 1; mCyc = 1; end
      return;
    end
    if (mCyc == 3) begin
      mIr = mem[mPc];
      mPc = mPc + 16'd1;
    end
    k = cls(mIr);
    if (mCyc == 4) begin
      if (k == 1 || k == 2) begin mZ = aluZero; mN = aluNegative; mC = aluCarry; end
      if (k == 6 && condTrue(mIr[11:8])) mPc = mPc + {{8{mIr[7]}}, mIr[7:0]};
      if (k == 5) begin mHalted = 1; mBusy = 0; return; end
    end
    len = (k == 3) ? 6 : 4;
    if (mCyc >= 4 && mCyc == len) begin
      mBusy = run;
      mCyc  = run ? 1 : 0;
    end else begin
      mCyc = mCyc + 1;
    end
  endtask

  task automatic checkAll();
    logic eRe, eWe, eRw, eRi, ePr, eAs, eWb, ePs;
    logic [1:0] eIt;
    logic [46:0] expV, actV;
    int k;
    eRe = 0; eWe = 0; eRw = 0; eRi = 0; ePr = 0; eAs = 0; eWb = 0; ePs = 0; eIt = 2'b00;
    if (mBusy) begin
      k = cls(mIr);
      if (mCyc == 1) begin eRe = 1; ePs = 1; end
      if (mCyc == 4) begin
        if (k == 1 || k == 2) begin
          ePr = 1; eWb = 1;
          eRw = !((k == 1 && mIr[7:4] == 4'hB) || mIr[15:12] == 4'hB);
          if (k == 2) begin
            eRi = 1;
            eIt = (mIr[15:12] == 4'h5 || mIr[15:12] == 4'h9 || mIr[15:12] == 4'hB) ? 2'b01 : 2'b10;
          end
        end
        if (k == 3) eRe = 1;
        if (k == 4) eWe = 1;
      end
      if (mCyc == 6) eRw = 1;
    end
    expV = {mIr, mPc, eRe, eWe, eRw, eIt, eRi, ePr, eAs, eWb, ePs, mIr[11:8], mHalted};
    actV = {instruction, programCounter, blockRamReadEnable, blockRamWriteEnable,
            registerFileWriteEnable, integerTypeSelectionLine, reg2OrImmediateSelectionLine,
            pcOrRegisterSelectionLine, addressFromRegOrDecoderSelectionLine,
            writeBackToRegRamOrALUSelectionLine, pcOrAluOutputRamReadSelectionLine,
            registerWriteAddress, halted};
    checkCount++;
    if (actV === expV) passCount++;
    else $display("FAIL outputs t=%0t got %h expected %h", $time, actV, expV);
  endtask

  task automatic checkLit(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clock);
    if (!reset) modelReset(); else modelStep();
    @(negedge clock);
    checkAll();
  endtask

  task automatic fillNop();
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'hF000;
  endtask

  // hold reset for a cycle, then release with run = 1; returns at FETCH
  task automatic restart();
    reset = 0; modelReset();
    tick();
    reset = 1; run = 1;
    tick();
  endtask

  function automatic logic [15:0] genWord();
    logic [15:0] w;
    logic [3:0] op;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2: w[15:12] = 4'h0;
      3, 4: begin
        op = 4'($urandom_range(1, 11));
        if (op == 4'h4) op = 4'h5;
        w[15:12] = op;
      end
      5: begin w[15:12] = 4'h4; w[7:4] = 4'h0; end
      6: begin w[15:12] = 4'h4; w[7:4] = 4'h4; end
      7: w[15:12] = 4'hC;
      8: w[15:12] = 4'($urandom_range(13, 15));
      default: ;
    endcase
    if (w[15:12] == 4'h4 && w[7:4] == 4'h1) w[7:4] = 4'h2;
    return w;
  endfunction

  initial begin
    modelReset();
    fillNop();
    mem[0] = 16'h0152;

    // reset state
    @(negedge clock);
    tick();
    checkLit("resetPc", programCounter, 16'h0000);
    checkLit("resetIr", instruction, 16'h0000);
    checkLit("resetEnables", {13'd0, blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable}, 16'h0000);
    checkLit("resetHalted", {15'd0, halted}, 16'h0000);
    checkLit("wrapResetPc", wPc, 16'hFFFF);

    // ADD r1,r2
    reset = 1; run = 1;
    tick();
    checkLit("fetchSelects", {14'd0, blockRamReadEnable, pcOrAluOutputRamReadSelectionLine}, 16'h0003);
    tick(); tick(); tick();
    checkLit("addIr", instruction, 16'h0152);
    checkLit("addWrite", {14'd0, writeBackToRegRamOrALUSelectionLine, registerFileWriteEnable}, 16'h0003);
    checkLit("addWaddr", {12'd0, registerWriteAddress}, 16'h0001);
    checkLit("addPc", programCounter, 16'h0001);
    checkLit("modelPc", mPc, 16'h0001);
    checkLit("wrapPc", wPc, 16'h0000);

    // reset during EXECUTE of ADD
    reset = 0; modelReset();
    #1;
    checkLit("abortWrite", {15'd0, registerFileWriteEnable}, 16'h0000);
    checkLit("abortPc", programCounter, 16'h0000);
    tick();
    reset = 1;
    tick();
    checkLit("postResetFetch", {14'd0, blockRamReadEnable, pcOrAluOutputRamReadSelectionLine}, 16'h0003);

    // LOAD r3,[r4], run dropped during MEM
    mem[0] = 16'h4304;
    restart();
    tick(); tick(); tick();
    checkLit("loadRead", {14'd0, blockRamReadEnable, pcOrAluOutputRamReadSelectionLine}, 16'h0002);
    tick();
    run = 0;
    tick();
    checkLit("loadWb", {14'd0, registerFileWriteEnable, writeBackToRegRamOrALUSelectionLine}, 16'h0002);
    for (int i = 0; i < 5; i++) tick();
    checkLit("idleNoFetch", {15'd0, blockRamReadEnable}, 16'h0000);
    run = 1;
    tick();
    checkLit("resumeFetch", {15'd0, blockRamReadEnable}, 16'h0001);

    // CMPI r1,#0 then BEQ -2 at PC 5, with Z = 1 and with Z = 0
    fillNop();
    mem[4] = 16'hB100;
    mem[5] = 16'hC0FE;
    aluZero = 1;
    restart();
    for (int i = 0; i < 24; i++) tick();
`ifdef DATAPATH_SEQ_BRANCH_EN
    checkLit("beqTaken", programCounter, 16'h0004);
`else
    checkLit("beqTaken", programCounter, 16'h0006);
`endif
    aluZero = 0;
    restart();
    for (int i = 0; i < 24; i++) tick();
    checkLit("beqNotTaken", programCounter, 16'h0006);

    // HALT
    mem[0] = 16'h4010;
    restart();
    for (int i = 0; i < 4; i++) tick();
    checkLit("halted", {15'd0, halted}, 16'h0001);
    for (int i = 0; i < 20; i++) tick();
    checkLit("haltEnables", {13'd0, blockRamReadEnable, blockRamWriteEnable, registerFileWriteEnable}, 16'h0000);
    checkLit("haltStays", {15'd0, halted}, 16'h0001);

    // randomized program with random run, flags and occasional reset
    for (int unsigned a = 0; a < 65536; a++) mem[a] = genWord();
    restart();
    for (int i = 0; i < 5000; i++) begin
      aluZero     = 1'($urandom);
      aluNegative = 1'($urandom);
      aluCarry    = 1'($urandom);
      run         = ($urandom_range(0, 9) != 0);
      if (!reset) reset = 1;
      else if ($urandom_range(0, 399) == 0) begin
        reset = 0; modelReset();
        #1;
        checkAll();
      end
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
